bpu_dyn: RTL and testbench

//  Parametrised dynamic branch predictor; successor to the static fetch-stage predictor.

---
 rtl/bpu_dyn_pkg.sv | 16 +
 rtl/bpu_dyn_if.sv | 28 ++
 rtl/bpu_dyn_pht.sv | 41 ++++
 rtl/bpu_dyn.sv | 81 ++++++++
 tb/tb_bpu_dyn.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/bpu_dyn_pkg.sv
// Shared definitions for the dynamic branch predictor: predictor modes,
// FSM state encodings and the weakly-not-taken counter reset value.
package bpu_dyn_pkg;

  localparam int BPU_MODE_STATIC  = 0;
  localparam int BPU_MODE_BIMODAL = 1;
  localparam int BPU_MODE_GSHARE  = 2;

  localparam logic [0:0] BPU_ST_INIT = 1'b0;
  localparam logic [0:0] BPU_ST_RUN  = 1'b1;

  function automatic int unsigned ctr_init(int unsigned w);
    return (32'd1 << (w - 1)) - 32'd1;
  endfunction

endpackage

// File: rtl/bpu_dyn_if.sv
// Fetch-side lookup and ex-side training signals of the branch predictor.
interface bpu_dyn_if;
  logic [31:0] pc_i;
  logic        inst_jal_i;
  logic        inst_jalr_i;
  logic        inst_bxx_i;
  logic [31:0] jb_imm_i;
  logic        prdt_taken_o;
  logic [31:0] prdt_addr_o;
  logic        upd_valid_i;
  logic [31:0] upd_pc_i;
  logic        upd_taken_i;
  logic        upd_mispred_i;
  logic        init_busy_o;
  logic [31:0] mispred_cnt_o;

  modport master (
    output pc_i, inst_jal_i, inst_jalr_i, inst_bxx_i, jb_imm_i,
    output upd_valid_i, upd_pc_i, upd_taken_i, upd_mispred_i,
    input  prdt_taken_o, prdt_addr_o, init_busy_o, mispred_cnt_o
  );

  modport slave (
    input  pc_i, inst_jal_i, inst_jalr_i, inst_bxx_i, jb_imm_i,
    input  upd_valid_i, upd_pc_i, upd_taken_i, upd_mispred_i,
    output prdt_taken_o, prdt_addr_o, init_busy_o, mispred_cnt_o
  );
endinterface

// File: rtl/bpu_dyn_pht.sv
// Pattern history table: saturating counters with one combinational read port
// and one write port shared by the init sweep and training updates.
module bpu_pht
  import bpu_dyn_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int IW      = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             init_we,
  input  logic [IW-1:0]    init_idx,
  input  logic             upd_we,
  input  logic [IW-1:0]    upd_idx,
  input  logic             upd_taken,
  input  logic [IW-1:0]    rd_idx,
  output logic [CTR_W-1:0] rd_ctr
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  logic [CTR_W-1:0] mem [ENTRIES];
  logic [CTR_W-1:0] upd_cur;

  assign rd_ctr  = mem[rd_idx];
  assign upd_cur = mem[upd_idx];

  // No reset on the array: the init sweep rewrites every entry after rst.
  always_ff @(posedge clk) begin
    if (init_we) begin
      mem[init_idx] <= CTR_INIT;
    end else if (upd_we) begin
      if (upd_taken && upd_cur != '1) begin
        mem[upd_idx] <= upd_cur + CTR_W'(1);
      end else if (!upd_taken && upd_cur != '0) begin
        mem[upd_idx] <= upd_cur - CTR_W'(1);
      end
    end
  end

endmodule

// File: rtl/bpu_dyn.sv
// Dynamic branch predictor: init sweep FSM, global history, index hash,
// same-cycle taken/target lookup and a saturating mispredict counter.
module bpu_dyn
  import bpu_dyn_pkg::*;
#(
  parameter int PHT_ENTRIES = 64,
  parameter int CTR_W       = 2,
  parameter int HIST_W      = 6,
  parameter int MODE        = BPU_MODE_GSHARE
) (
  input  logic      clk,
  input  logic      rst,
  bpu_dyn_if.slave  bus
);

  localparam int IW = $clog2(PHT_ENTRIES);

  logic [0:0]        state;
  logic [IW-1:0]     sweep_idx;
  logic [HIST_W-1:0] ghr;
  logic [31:0]       mispred_cnt;
  logic [IW-1:0]     rd_idx;
  logic [IW-1:0]     upd_idx;
  logic [CTR_W-1:0]  rd_ctr;
  logic              busy;
  logic              upd_we;
  logic              bxx_taken;

  function automatic logic [IW-1:0] pht_idx(logic [31:0] pc, logic [HIST_W-1:0] h);
    logic [IW-1:0] base;
    base = pc[IW+1:2];
    if (MODE == BPU_MODE_GSHARE) base = base ^ IW'(h);
    return base;
  endfunction

  assign busy    = (state == BPU_ST_INIT);
  assign upd_we  = !busy && bus.upd_valid_i;
  assign rd_idx  = pht_idx(bus.pc_i, ghr);
  assign upd_idx = pht_idx(bus.upd_pc_i, ghr);

  always_comb begin
    bxx_taken = rd_ctr[CTR_W-1];
    if (MODE == BPU_MODE_STATIC || busy) bxx_taken = bus.jb_imm_i[31];
  end

  assign bus.prdt_taken_o  = !bus.inst_jalr_i &&
                             (bus.inst_jal_i || (bus.inst_bxx_i && bxx_taken));
  assign bus.prdt_addr_o   = bus.pc_i + bus.jb_imm_i;
  assign bus.init_busy_o   = busy;
  assign bus.mispred_cnt_o = mispred_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BPU_ST_INIT;
      sweep_idx   <= '0;
      ghr         <= '0;
      mispred_cnt <= '0;
    end else if (busy) begin
      sweep_idx <= sweep_idx + IW'(1);
      if (sweep_idx == IW'(PHT_ENTRIES - 1)) state <= BPU_ST_RUN;
    end else if (bus.upd_valid_i) begin
      ghr <= HIST_W'({ghr, bus.upd_taken_i});
      if (bus.upd_mispred_i && mispred_cnt != '1) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end

  bpu_pht #(
    .ENTRIES (PHT_ENTRIES),
    .CTR_W   (CTR_W)
  ) u_pht (
    .clk       (clk),
    .init_we   (busy),
    .init_idx  (sweep_idx),
    .upd_we    (upd_we),
    .upd_idx   (upd_idx),
    .upd_taken (bus.upd_taken_i),
    .rd_idx    (rd_idx),
    .rd_ctr    (rd_ctr)
  );

endmodule

// File: tb/tb_bpu_dyn.sv
// Three predictors (static, bimodal, gshare) on shared stimulus, checked each
// cycle against an array-based model, plus hand-computed directed checks.
module tb_bpu_dyn;

  logic        clk = 1'b0;
  logic        rst;
  logic        jal, jalr, bxx;
  logic [31:0] pc, imm, upd_pc;
  logic        upd_valid, upd_taken, upd_mispred;

  logic        taken_o [3];
  logic [31:0] addr_o  [3];
  logic        busy_o  [3];
  logic [31:0] mcnt_o  [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gm
    bpu_dyn_if bus ();
    assign bus.pc_i          = pc;
    assign bus.inst_jal_i    = jal;
    assign bus.inst_jalr_i   = jalr;
    assign bus.inst_bxx_i    = bxx;
    assign bus.jb_imm_i      = imm;
    assign bus.upd_valid_i   = upd_valid;
    assign bus.upd_pc_i      = upd_pc;
    assign bus.upd_taken_i   = upd_taken;
    assign bus.upd_mispred_i = upd_mispred;
    assign taken_o[g] = bus.prdt_taken_o;
    assign addr_o[g]  = bus.prdt_addr_o;
    assign busy_o[g]  = bus.init_busy_o;
    assign mcnt_o[g]  = bus.mispred_cnt_o;

    bpu_dyn #(
      .PHT_ENTRIES (64),
      .CTR_W       (2),
      .HIST_W      (6),
      .MODE        (g)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: per-mode counter arrays, history and stats; sweep as a countdown.
  int unsigned ctr  [3][64];
  int unsigned ghr  [3];
  int unsigned mcnt [3];
  int          sweep_left;

  function automatic int unsigned midx(int m, logic [31:0] p);
    int unsigned i;
    i = (p >> 2) & 32'd63;
    if (m == 2) i = i ^ ghr[m];
    return i;
  endfunction

  function automatic logic mtaken(int m);
    if (jalr) return 1'b0;
    if (jal)  return 1'b1;
    if (!bxx) return 1'b0;
    if (m == 0 || sweep_left != 0) return imm[31];
    return ctr[m][midx(m, pc)] >= 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int m = 0; m < 3; m++) begin
        for (int i = 0; i < 64; i++) ctr[m][i] = 1;
        ghr[m]  = 0;
        mcnt[m] = 0;
      end
      sweep_left = 64;
    end else if (sweep_left != 0) begin
      sweep_left = sweep_left - 1;
    end else if (upd_valid) begin
      for (int m = 0; m < 3; m++) begin
        int unsigned i;
        i = midx(m, upd_pc);
        if (upd_taken) ctr[m][i] = (ctr[m][i] == 3) ? 3 : ctr[m][i] + 1;
        else           ctr[m][i] = (ctr[m][i] == 0) ? 0 : ctr[m][i] - 1;
        ghr[m] = ((ghr[m] << 1) | upd_taken) & 32'd63;
        if (upd_mispred && mcnt[m] != 32'hFFFF_FFFF) mcnt[m] = mcnt[m] + 1;
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      for (int m = 0; m < 3; m++) begin
        chk($sformatf("m%0d_taken", m), 32'(taken_o[m]), 32'(mtaken(m)));
        chk($sformatf("m%0d_addr", m), addr_o[m], pc + imm);
        chk($sformatf("m%0d_busy", m), 32'(busy_o[m]), 32'(sweep_left != 0));
        chk($sformatf("m%0d_mcnt", m), mcnt_o[m], mcnt[m]);
      end
    end
  end

  task automatic next();
    @(negedge clk);
  endtask

  task automatic set_upd(logic v, logic [31:0] p, logic t, logic mp);
    upd_valid = v; upd_pc = p; upd_taken = t; upd_mispred = mp;
  endtask

  int busy_cnt;

  initial begin
    rst = 1'b1; jal = 0; jalr = 0; bxx = 0; pc = '0; imm = '0;
    set_upd(0, '0, 0, 0);
    next();
    rst = 1'b0; chk_en = 1'b1;
    bxx = 1; pc = 32'h100; imm = 32'hFFFF_FFF8;
    #3;
    chk("sweep_btfn_taken", 32'(taken_o[1]), 32'd1);
    chk("sweep_btfn_addr", addr_o[1], 32'h0000_00F8);
    chk("reset_mcnt", mcnt_o[2], 32'd0);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy_o[1]) break;
      busy_cnt++;
      next(); #3;
    end
    chk("busy_len", busy_cnt, 32'd64);

    next(); pc = 32'h40; imm = 32'd16; #3;
    chk("bimodal_init_nt", 32'(taken_o[1]), 32'd0);
    next(); set_upd(1, 32'h40, 1, 1);
    next();
    next(); set_upd(0, '0, 0, 0); #3;
    chk("bimodal_trained", 32'(taken_o[1]), 32'd1);
    chk("bimodal_addr", addr_o[1], 32'h50);
    chk("static_fwd_nt", 32'(taken_o[0]), 32'd0);
    chk("mcnt_two", mcnt_o[1], 32'd2);

    next(); set_upd(1, 32'h40, 1, 0);
    repeat (4) next();
    set_upd(1, 32'h40, 0, 0);
    next(); set_upd(0, '0, 0, 0); #3;
    chk("sat_still_taken", 32'(taken_o[1]), 32'd1);
    next(); set_upd(1, 32'h40, 0, 0); #3;
    chk("rbw_pre_dec", 32'(taken_o[1]), 32'd1);
    next(); set_upd(0, '0, 0, 0); #3;
    chk("sat_now_nt", 32'(taken_o[1]), 32'd0);

    next(); set_upd(1, 32'h40, 1, 0); #3;
    chk("rbw_same_cycle", 32'(taken_o[1]), 32'd0);
    next(); set_upd(0, '0, 0, 0); #3;
    chk("rbw_next_cycle", 32'(taken_o[1]), 32'd1);

    next(); rst = 1'b1;
    next(); rst = 1'b0; #3;
    chk("rerun_busy", 32'(busy_o[1]), 32'd1);
    chk("rerun_mcnt", mcnt_o[1], 32'd0);
    repeat (64) next();
    #3;
    chk("rerun_done", 32'(busy_o[1]), 32'd0);
    chk("rerun_ctr_cleared", 32'(taken_o[1]), 32'd0);

    bxx = 0;
    next(); set_upd(1, 32'h80, 1, 0);
    next(); set_upd(1, 32'h180, 0, 0);
    repeat (5) begin next(); set_upd(1, 32'h3FC, 0, 0); end
    next(); set_upd(0, '0, 0, 0); bxx = 1; pc = 32'h80; imm = 32'd16; #3;
    chk("gshare_split_taken", 32'(taken_o[2]), 32'd1);
    chk("bimodal_alias_nt", 32'(taken_o[1]), 32'd0);

    next(); bxx = 0; jal = 1; pc = 32'h200; imm = 32'h40; #3;
    for (int m = 0; m < 3; m++) chk($sformatf("jal_m%0d", m), 32'(taken_o[m]), 32'd1);
    chk("jal_addr", addr_o[2], 32'h240);
    next(); jal = 0; jalr = 1; #3;
    for (int m = 0; m < 3; m++) chk($sformatf("jalr_m%0d", m), 32'(taken_o[m]), 32'd0);

    for (int n = 0; n < 3000; n++) begin
      int sel;
      next();
      sel = $urandom_range(0, 3);
      jal = (sel == 1); jalr = (sel == 2); bxx = (sel == 3);
      pc  = 32'($urandom_range(0, 255)) << 2;
      imm = $urandom;
      set_upd(($urandom_range(0, 2) != 0), 32'($urandom_range(0, 255)) << 2,
              1'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 999) == 0);
    end
    next(); rst = 0; set_upd(0, '0, 0, 0);
    next();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
